// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified Y86 memory between the fetch and memory stages:
// one grant at a time, variable-latency req/ack sequencing, range check and timeout abort.
module mem_port_arbiter #(
  parameter  int unsigned MEM_SIZE = 4096,
  parameter  int unsigned TIMEOUT  = 15,
  localparam int unsigned XLEN     = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            f_req_i,
  input  logic [XLEN-1:0] f_addr_i,
  output logic [XLEN-1:0] f_rdata_o,
  output logic            f_done_o,
  output logic            f_err_o,
  output logic            f_stall_o,
  input  logic            m_req_i,
  input  logic            m_we_i,
  input  logic [XLEN-1:0] m_addr_i,
  input  logic [XLEN-1:0] m_wdata_i,
  output logic [XLEN-1:0] m_rdata_o,
  output logic            m_done_o,
  output logic            m_err_o,
  output logic            m_stall_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i,
  output logic            busy_o
);

  localparam int unsigned     CNT_W        = $clog2(TIMEOUT + 1);
  localparam logic [XLEN-1:0] LAST_OK_ADDR = XLEN'(MEM_SIZE - 8);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_M = 2'd1,
    BUSY_F = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]   f_rdata_q, f_rdata_d;
  logic              f_done_q, f_done_d;
  logic              f_err_q, f_err_d;
  logic [XLEN-1:0]   m_rdata_q, m_rdata_d;
  logic              m_done_q, m_done_d;
  logic              m_err_q, m_err_d;

  // A requester is not re-served in the cycle its own completion is presented.
  logic f_elig, m_elig;
  assign f_elig = f_req_i & ~f_done_q;
  assign m_elig = m_req_i & ~m_done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_rdata_q   <= '0;
      f_done_q    <= 1'b0;
      f_err_q     <= 1'b0;
      m_rdata_q   <= '0;
      m_done_q    <= 1'b0;
      m_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_rdata_q   <= f_rdata_d;
      f_done_q    <= f_done_d;
      f_err_q     <= f_err_d;
      m_rdata_q   <= m_rdata_d;
      m_done_q    <= m_done_d;
      m_err_q     <= m_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_rdata_d   = f_rdata_q;
    f_done_d    = 1'b0;
    f_err_d     = f_err_q;
    m_rdata_d   = m_rdata_q;
    m_done_d    = 1'b0;
    m_err_d     = m_err_q;

    case (state_q)
      IDLE: begin
        // M stage holds the older instruction, so it wins a tie.
        if (m_elig) begin
          if (m_addr_i > LAST_OK_ADDR) begin
            m_done_d  = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = m_we_i;
            mem_addr_d  = m_addr_i;
            mem_wdata_d = m_wdata_i;
            cnt_d       = '0;
            state_d     = BUSY_M;
          end
        end else if (f_elig) begin
          if (f_addr_i > LAST_OK_ADDR) begin
            f_done_d  = 1'b1;
            f_err_d   = 1'b1;
            f_rdata_d = '0;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = f_addr_i;
            mem_wdata_d = '0;
            cnt_d       = '0;
            state_d     = BUSY_F;
          end
        end
      end

      BUSY_M, BUSY_F: begin
        // Ack takes precedence over an expiring timeout in the same cycle.
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == BUSY_M) begin
            m_done_d = 1'b1;
            m_err_d  = 1'b0;
            if (!mem_we_q) begin
              m_rdata_d = mem_rdata_i;
            end
          end else begin
            f_done_d  = 1'b1;
            f_err_d   = 1'b0;
            f_rdata_d = mem_rdata_i;
          end
        end else if (cnt_q == CNT_MAX) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == BUSY_M) begin
            m_done_d  = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = '0;
          end else begin
            f_done_d  = 1'b1;
            f_err_d   = 1'b1;
            f_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Stalls follow the requests directly so the pipeline sees them in the same cycle.
  assign f_stall_o = f_req_i & ~f_done_q & ~rst_i;
  assign m_stall_o = m_req_i & ~m_done_q & ~rst_i;

  assign f_rdata_o   = f_rdata_q;
  assign f_done_o    = f_done_q;
  assign f_err_o     = f_err_q;
  assign m_rdata_o   = m_rdata_q;
  assign m_done_o    = m_done_q;
  assign m_err_o     = m_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares the single-port unified Y86 memory between the fetch stage (instruction reads) and the memory stage (data reads/writes). It grants one requester at a time, runs a variable-latency req/ack transaction on the memory port, and returns data plus an address-error flag. It produces per-stage stall outputs that the pipeline control logic ORs into its F/D stall and bubble decisions. It sits between the F and M stage logic and the memory model.

## Interface
- MEM_SIZE, 4096: memory size in bytes; valid 8-byte access requires addr <= MEM_SIZE-8.
- TIMEOUT, 15: maximum cycles a granted transaction waits for mem_ack before being aborted with error.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- f_req  in  1  fetch read request; held high until f_done.
- f_addr  in  64  fetch byte address.
- f_rdata  out  64  fetch read data; valid when f_done=1.
- f_done  out  1  one-cycle completion pulse for fetch.
- f_err  out  1  address error, qualified by f_done; drives stat ADR.
- f_stall  out  1  f_req & ~f_done (combinational).
- m_req  in  1  memory-stage request; held high until m_done.
- m_we  in  1  1 = write, 0 = read; held stable with m_req.
- m_addr  in  64  data byte address.
- m_wdata  in  64  write data.
- m_rdata  out  64  read data; valid when m_done=1 and m_we=0.
- m_done  out  1  one-cycle completion pulse for memory stage.
- m_err  out  1  address error, qualified by m_done.
- m_stall  out  1  m_req & ~m_done (combinational).
- mem_req  out  1  memory port request; registered.
- mem_we  out  1  memory port write enable; registered.
- mem_addr  out  64  memory port address; registered.
- mem_wdata  out  64  memory port write data; registered.
- mem_rdata  in  64  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, BUSY_M, BUSY_F.
- In IDLE, sample the requests each cycle. A request is ignored in the cycle its own done is high.
- Priority when both requests are eligible:
  - m_req wins, since the M stage holds the older instruction.
  - f_req is granted only when m_req is not eligible.
- Range check in IDLE: if the winner's addr > MEM_SIZE-8:
  - no memory transaction is issued and the state stays IDLE;
  - next cycle: done=1, err=1, rdata=0.
- Valid grant: latch addr, we and wdata onto the mem_* outputs, set mem_req=1, go to BUSY_M or BUSY_F, and clear the timeout counter.
  - For fetch, mem_we is forced to 0.
- While BUSY_x, mem_ack=1 ends the transaction:
  - capture mem_rdata into x_rdata;
  - next cycle: x_done=1, x_err=0, mem_req=0, state IDLE.
- Timeout:
  - The counter is clog2(TIMEOUT+1) bits wide and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT, the transaction aborts: mem_req=0, x_done=1, x_err=1, x_rdata=0, state IDLE.
  - If ack and timeout occur in the same cycle, ack wins.
- A stray mem_ack while mem_req=0 is ignored, including a late ack after a timeout.
- rdata and err hold their values until the next done for that requester.
- Writes: m_rdata is unspecified (holds its previous value).

## Timing
- Reset: all outputs 0, state IDLE, counter 0. This takes effect immediately and asynchronously.
  - Reset mid-transaction drops mem_req at once and abandons the transaction; no done is issued.
- Latency, request in cycle 0 with ack arriving n cycles after mem_req rises:
  - mem_req is high from cycle 1;
  - done is in cycle n+1 (minimum cycle 2, for an ack in cycle 1).
- Out-of-range request in cycle 0: done/err in cycle 1.
- Timeout with no ack: mem_req is high in cycles 1..TIMEOUT+1 and done/err arrives in cycle TIMEOUT+2.
- Back-to-back operation:
  - The other requester can be granted in the same cycle that a done is emitted, since IDLE is re-entered that cycle.
  - Peak throughput is one transaction per 2 cycles with zero-wait memory.
- A requester must deassert req, or change its address for a new request, in the cycle following its done.
- mem_* outputs are stable for the whole BUSY period.

## Test plan
- Single fetch, f_addr=0x100, ack 1 cycle after mem_req -> mem_req cycles 1..1, f_done cycle 2, f_rdata=mem_rdata, f_err=0, f_stall high cycles 0-1.
- Simultaneous f_req and m_req (m_we=1, m_addr=0x200, m_wdata=0xDEAD): with 0-wait ack -> the M write is issued first (mem_we=1), m_done cycle 2. Then the fetch is granted in cycle 2, f_done cycle 4, and f_stall stays high through cycle 3.
- m_addr=MEM_SIZE-7 -> no mem_req, m_done=1, m_err=1 in cycle 1; m_addr=MEM_SIZE-8 -> normal transaction.
- No ack with TIMEOUT=15 -> mem_req high cycles 1..16, f_done=1 and f_err=1 in cycle 17. A late ack in cycle 18 is ignored (no extra done).
- rst asserted mid-BUSY_M with 3-cycle ack latency -> mem_req, busy and stalls drop asynchronously, no m_done. A fresh request after reset release completes normally.
- Ack on the exact TIMEOUT cycle -> completes with err=0 and the captured data.
